// File: rtl/posit_normalize_arbiter_es3.sv
// posit_normalize_es3
//   Combinational normaliser: turns a serialized posit value (es = 3) into a
//   32-bit posit with round-to-nearest-even. Results never round to zero or
//   to NaR; out-of-range magnitudes clamp to minpos/maxpos.
//   Serialized layout (38 bits):
//     [37] sgn | [36:28] scale (signed) | [27:2] fraction (hidden bit implied)
//     [1] inf | [0] zero
//   Ports:
//     data      serialized input value
//     truncated sticky flag for bits already dropped below the fraction
//     result    32-bit posit
//     inf, zero special-value flags (inf wins when both are set)
//
// posit_normalize_arbiter_es3
//   Shares one posit_normalize_es3 between NREQ requesters. A round-robin
//   arbiter feeds a two-stage pipeline (input register -> normaliser ->
//   output register). Results leave in grant order, tagged by requester.
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     req_valid/req_ready   per-requester handshake (ready is one-hot or 0)
//     req_data              38-bit slice per requester, slice i = [38*i +: 38]
//     req_truncated         per-requester sticky flag
//     out_valid/out_ready   result handshake
//     out_result/out_inf/out_zero/out_tag  registered result fields
//     busy                  either pipeline stage holds data
//
// Handshake rule (all valid/ready pairs): a transfer happens on a rising edge
// where valid and ready are both high. A producer holding valid with ready
// low keeps its data stable only if it wants that data accepted; it may drop
// valid at any time, and ready never depends on data, only on valid.

module posit_normalize_es3 (
  input  logic [37:0] data,
  input  logic        truncated,
  output logic [31:0] result,
  output logic        inf,
  output logic        zero
);

  logic               sgn;
  logic signed [8:0]  scale;
  logic [5:0]         k;
  logic [4:0]         sh;
  logic [95:0]        seed;
  logic [95:0]        v;
  logic [30:0]        body;
  logic               round_up;
  logic [31:0]        rounded;
  logic [31:0]        mag;

  always_comb begin
    sgn      = data[37];
    scale    = data[36:28];
    // Regime k = floor(scale / 8); the exponent field is scale mod 8.
    k        = scale[8:3];
    sh       = '0;
    seed     = '0;
    v        = '0;
    body     = '0;
    round_up = 1'b0;
    rounded  = '0;
    mag      = '0;
    inf      = 1'b0;
    zero     = 1'b0;
    result   = '0;

    if (!k[5]) begin
      // k >= 0: k+1 ones then a zero. Shift "10" right filling with ones.
      seed = {2'b10, scale[2:0], data[27:2], 65'b0};
      sh   = k[4:0];
      v    = ~((~seed) >> sh);
    end else begin
      // k < 0: -k zeros then a one. -k-1 == ~k in two's complement.
      seed = {2'b01, scale[2:0], data[27:2], 65'b0};
      sh   = ~k[4:0];
      v    = seed >> sh;
    end

    body     = v[95:65];
    round_up = v[64] & (v[65] | (|v[63:0]) | truncated);
    rounded  = {1'b0, body} + {31'b0, round_up};

    if (scale >= 9'sd240) begin
      mag = 32'h7fff_ffff;
    end else if (scale < -9'sd240) begin
      mag = 32'h0000_0001;
    end else if (rounded[31]) begin
      mag = 32'h7fff_ffff;
    end else begin
      mag = rounded;
    end

    if (data[1]) begin
      inf    = 1'b1;
      result = 32'h8000_0000;
    end else if (data[0]) begin
      zero   = 1'b1;
      result = 32'h0000_0000;
    end else begin
      result = sgn ? (~mag + 32'd1) : mag;
    end
  end

endmodule

module posit_normalize_arbiter_es3 #(
  parameter int   NREQ = 4,
  parameter int   TAGW = $clog2(NREQ),
  localparam int  POSIT_SERIALIZED_WIDTH_ES3 = 38
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [NREQ-1:0]                            req_valid,
  output logic [NREQ-1:0]                            req_ready,
  input  logic [NREQ*POSIT_SERIALIZED_WIDTH_ES3-1:0] req_data,
  input  logic [NREQ-1:0]                            req_truncated,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [31:0]                                out_result,
  output logic                                       out_inf,
  output logic                                       out_zero,
  output logic [TAGW-1:0]                            out_tag,
  output logic                                       busy
);

  localparam int PW = POSIT_SERIALIZED_WIDTH_ES3;

  logic [TAGW-1:0] rr_ptr;
  logic [TAGW-1:0] grant;
  logic [TAGW-1:0] rr_next;
  logic            any_valid;
  logic            s1_load;
  logic            s2_load;

  logic            s1_valid;
  logic [PW-1:0]   s1_data;
  logic            s1_trunc;
  logic [TAGW-1:0] s1_tag;
  logic            s2_valid;

  logic [31:0]     norm_result;
  logic            norm_inf;
  logic            norm_zero;

  // Round-robin scan: walking offsets from high to low lets the smallest
  // offset from rr_ptr win.
  always_comb begin
    grant     = '0;
    any_valid = |req_valid;
    for (int i = NREQ - 1; i >= 0; i--) begin
      int idx;
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) grant = TAGW'(idx);
    end
  end

  assign rr_next   = (int'(grant) == NREQ - 1) ? '0 : grant + TAGW'(1);
  assign s2_load   = s1_valid & (~s2_valid | out_ready);
  assign s1_load   = (~s1_valid | s2_load) & any_valid;
  // Gated by rst_n so no requester sees ready while the pipeline is held in reset.
  assign req_ready = (s1_load && rst_n) ? (NREQ'(1) << grant) : '0;
  assign out_valid = s2_valid;
  assign busy      = s1_valid | s2_valid;

  posit_normalize_es3 u_norm (
    .data      (s1_data),
    .truncated (s1_trunc),
    .result    (norm_result),
    .inf       (norm_inf),
    .zero      (norm_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_trunc   <= 1'b0;
      s1_tag     <= '0;
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_inf    <= 1'b0;
      out_zero   <= 1'b0;
      out_tag    <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_data  <= req_data[int'(grant)*PW +: PW];
        s1_trunc <= req_truncated[grant];
        s1_tag   <= grant;
        rr_ptr   <= rr_next;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        s2_valid   <= 1'b1;
        out_result <= norm_result;
        out_inf    <= norm_inf;
        out_zero   <= norm_zero;
        out_tag    <= s1_tag;
      end else if (out_valid && out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule
